// File: rtl/cpc_ram_pkg.sv
// Shared constants and types for the CPC RAM-expansion controller.
// Covers the operating modes, the capture FSM states and the bank-mapping schemes.
package cpc_ram_pkg;

  localparam int MODE_464  = 0;
  localparam int MODE_6128 = 1;
  localparam int MODE_UNIV = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    WAIT_REL = 2'd2
  } fsm_t;

  localparam logic [2:0] BBB_DEFAULT = 3'b000;
  localparam logic [2:0] BBB_TOP     = 3'b001;
  localparam logic [2:0] BBB_FULL    = 3'b010;
  localparam logic [2:0] BBB_SPLIT   = 3'b011;

  localparam logic [1:0] PORT_DATA_TAG = 2'b11;
  localparam logic [1:0] BLK_1         = 2'b01;
  localparam logic [1:0] BLK_3         = 2'b11;

endpackage

// File: rtl/cpc_iowr_filter.sv
// Glitch-filtered capture of bank-select IO writes.
// A write must qualify for FILTER_CYCLES samples; it is committed when the strobe is released.
module cpc_iowr_filter
  import cpc_ram_pkg::*;
#(
  parameter int EXT_BITS      = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          adr_hi,
  input  logic                iorq_b,
  input  logic                wr_b,
  input  logic [7:0]          data,
  output logic [EXT_BITS+5:0] hold,
  output logic                commit
);

  localparam int         CW = EXT_BITS + 6;
  localparam logic [2:0] FC = 3'(FILTER_CYCLES);

  logic          iorq_m;
  logic          iorq_s;
  logic          wr_m;
  logic          wr_s;
  logic          hit;
  logic          released;
  logic [2:0]    cnt;
  logic [CW-1:0] cap;
  fsm_t          state;
  logic          unused_adr;

  generate
    if (EXT_BITS > 0) begin : g_ext
      assign cap = {~adr_hi[EXT_BITS-1:0], data[5:0]};
    end else begin : g_noext
      assign cap = data[5:0];
    end
  endgenerate

  assign unused_adr = ^adr_hi[6:EXT_BITS];
  assign hit        = !iorq_s && !wr_s && !adr_hi[7] && (data[7:6] == PORT_DATA_TAG);
  assign released   = iorq_s || wr_s;
  assign commit     = (state == WAIT_REL) && released;

  // Two-flop synchronisers for the asynchronous Z80 strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      iorq_m <= 1'b1;
      iorq_s <= 1'b1;
      wr_m   <= 1'b1;
      wr_s   <= 1'b1;
    end else begin
      iorq_m <= iorq_b;
      iorq_s <= iorq_m;
      wr_m   <= wr_b;
      wr_s   <= wr_m;
    end
  end

  // Qualify, capture and wait-for-release state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            cnt <= 3'd1;
            if (FC == 3'd1) begin
              hold  <= cap;
              state <= WAIT_REL;
            end else begin
              state <= QUAL;
            end
          end
        end
        QUAL: begin
          if (hit) begin
            cnt <= cnt + 3'd1;
            if ((cnt + 3'd1) == FC) begin
              hold  <= cap;
              state <= WAIT_REL;
            end
          end else begin
            cnt   <= 3'd0;
            state <= IDLE;
          end
        end
        WAIT_REL: begin
          if (released) begin
            cnt   <= 3'd0;
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= 3'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpld_ram_xmem.sv
// CPC RAM-expansion controller: filtered bank-select capture plus memory decode
// driven from the committed configuration register.
module cpld_ram_xmem
  import cpc_ram_pkg::*;
#(
  parameter int EXT_BITS      = 2,
  parameter int FILTER_CYCLES = 2,
  parameter int MODE          = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          adr_hi,
  input  logic                iorq_b,
  input  logic                mreq_b,
  input  logic                wr_b,
  input  logic                ramrd_b,
  input  logic [7:0]          data,
  input  logic                mode464,
  input  logic                shadowhi,
  output logic                ramdis,
  output logic                ramcs_b,
  output logic [EXT_BITS+4:0] ramadrhi,
  output logic                ramoe_b,
  output logic                ramwe_b,
  output logic [EXT_BITS+5:0] cfg_q,
  output logic                cfg_wr_pulse
);

  localparam int BW = EXT_BITS + 3;
  localparam int CW = EXT_BITS + 6;

  logic [CW-1:0] hold;
  logic          commit;
  logic          m;
  logic          cs_int;
  logic [BW-1:0] s;
  logic [BW-1:0] b;
  logic [BW-1:0] bank;
  logic [2:0]    bbb;
  logic [1:0]    blk;
  logic [BW+1:0] addr;

  cpc_iowr_filter #(
    .EXT_BITS      (EXT_BITS),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .adr_hi (adr_hi),
    .iorq_b (iorq_b),
    .wr_b   (wr_b),
    .data   (data),
    .hold   (hold),
    .commit (commit)
  );

  // Committed configuration register and its one-cycle update strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q        <= '0;
      cfg_wr_pulse <= 1'b0;
    end else begin
      cfg_wr_pulse <= commit;
      if (commit) begin
        cfg_q <= hold;
      end
    end
  end

  // Memory decode: the shadow bank backs unmapped blocks; a selected bank equal to it aliases down
  always_comb begin
    m    = (MODE == MODE_464) || ((MODE == MODE_UNIV) && mode464);
    s    = '0;
    s[2] = shadowhi;
    s[1:0] = 2'b11;
    bank = cfg_q[CW-1:3];
    bbb  = cfg_q[2:0];
    blk  = adr_hi[7:6];
    b    = (bank == s) ? {s[BW-1:1], 1'b0} : bank;
    cs_int = !m;
    addr   = {s, blk};
    case (bbb)
      BBB_DEFAULT: begin
        cs_int = !m;
        addr   = {s, blk};
      end
      BBB_TOP: begin
        if (blk == BLK_3) begin
          cs_int = 1'b0;
          addr   = {b, BLK_3};
        end else begin
          cs_int = !m;
          addr   = {s, blk};
        end
      end
      BBB_FULL: begin
        cs_int = 1'b0;
        addr   = {b, blk};
      end
      BBB_SPLIT: begin
        if (blk == BLK_3) begin
          cs_int = 1'b0;
          addr   = {b, BLK_3};
        end else begin
          cs_int = !m;
          addr   = {s, blk[1] | blk[0], blk[0]};
        end
      end
      default: begin
        if (blk == BLK_1) begin
          cs_int = 1'b0;
          addr   = {b, bbb[1:0]};
        end else begin
          cs_int = !m;
          addr   = {s, blk};
        end
      end
    endcase
    // Bank 0 on a 6128 is the internal RAM, whatever the scheme
    cs_int = cs_int | (!m && (bank == '0));
  end

  assign ramcs_b  = cs_int | mreq_b;
  assign ramdis   = !cs_int;
  assign ramadrhi = addr;
  assign ramoe_b  = ramrd_b;
  assign ramwe_b  = wr_b;

endmodule
